// File: rtl/cache_control_pkg.sv
// Purpose: shared types and constants for the cache controller slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_types;

  // Default width of each performance counter.
  localparam int CNT_WIDTH_DEFAULT = 16;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Purpose: bundles the CPU request, array strobe and physical memory signals of the controller.
// Latency: n/a (wiring only).
// Backpressure: CPU holds mem_read/mem_write until mem_resp; pmem requests are held until pmem_resp.
interface cache_control_if;

  // CPU side
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_byte_enable;
  logic       mem_resp;

  // Array status from the existing datapath
  logic       hit;
  logic       dirty;

  // Physical memory side
  logic       pmem_resp;
  logic       pmem_read;
  logic       pmem_write;

  // Datapath steering and array write strobes
  logic       pmem_addr_sel;
  logic       data_src_sel;
  logic       data_load;
  logic       tag_load;
  logic       valid_load;
  logic       dirty_load;
  logic       dirty_in;

  // Environment side: CPU, arrays and memory model.
  modport master (
    output mem_read, mem_write, mem_byte_enable, hit, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_src_sel,
           data_load, tag_load, valid_load, dirty_load, dirty_in
  );

  // Controller side.
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, hit, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_src_sel,
           data_load, tag_load, valid_load, dirty_load, dirty_in
  );

endinterface

// File: rtl/cache_control_sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc one cycle after it is seen.
// Backpressure: none; inc is sampled every cycle.
module sat_counter
  import cache_types::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Count events, holding at the maximum value once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Purpose: sequences hit service, dirty-line writeback and line allocate for a write-back cache.
// Latency: hits complete combinationally; a miss costs one IDLE cycle + memory cycles + one IDLE hit cycle.
// Backpressure: CPU request is held until mem_resp; pmem_read/pmem_write are held until pmem_resp.
module cache_control
  import cache_types::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_if.slave       bus,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  cache_ctrl_state_t state;
  cache_ctrl_state_t state_nxt;

  logic req;
  logic miss_inc;
  logic wb_inc;

  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  logic data_src_sel;
  logic data_load;
  logic tag_load;
  logic valid_load;
  logic dirty_load;
  logic dirty_in;

  // A write wins when both request lines are up, so any request is simply either line.
  assign req = bus.mem_read | bus.mem_write;

  // State register; reset forces IDLE asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode; everything is qualified by rst_n so reset silences outputs at once.
  always_comb begin
    state_nxt     = state;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_src_sel  = 1'b0;
    data_load     = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    dirty_in      = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (bus.hit) begin
            mem_resp = 1'b1;
            if (bus.mem_write) begin
              // Merged CPU line goes into the data array; only a real byte write dirties it.
              data_src_sel = 1'b1;
              data_load    = 1'b1;
              if (bus.mem_byte_enable != 2'b00) begin
                dirty_load = 1'b1;
                dirty_in   = 1'b1;
              end
            end
          end else begin
            miss_inc  = 1'b1;
            state_nxt = bus.dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end

      WRITEBACK: begin
        // Victim line goes out at the stored tag address.
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          wb_inc    = 1'b1;
          state_nxt = ALLOCATE;
        end
      end

      ALLOCATE: begin
        // Fill from the CPU line address; install a clean, valid line on completion.
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          data_load  = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
          state_nxt  = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!rst_n) begin
      state_nxt     = IDLE;
      miss_inc      = 1'b0;
      wb_inc        = 1'b0;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      data_src_sel  = 1'b0;
      data_load     = 1'b0;
      tag_load      = 1'b0;
      valid_load    = 1'b0;
      dirty_load    = 1'b0;
      dirty_in      = 1'b0;
    end
  end

  assign bus.mem_resp      = mem_resp;
  assign bus.pmem_read     = pmem_read;
  assign bus.pmem_write    = pmem_write;
  assign bus.pmem_addr_sel = pmem_addr_sel;
  assign bus.data_src_sel  = data_src_sel;
  assign bus.data_load     = data_load;
  assign bus.tag_load      = tag_load;
  assign bus.valid_load    = valid_load;
  assign bus.dirty_load    = dirty_load;
  assign bus.dirty_in      = dirty_in;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Purpose: directed scoreboard bench for cache_control with 4-bit counters.
// Latency: expectations are per cycle; outputs are sampled on the falling edge.
// Backpressure: stimulus pushes one expectation per cycle, monitor pops one per falling edge.
module tb_cache_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] miss_count;
  logic [3:0] wb_count;

  cache_control_if bus ();

  cache_control #(.CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector bit order:
  // [9] mem_resp [8] pmem_read [7] pmem_write [6] pmem_addr_sel [5] data_src_sel
  // [4] data_load [3] tag_load [2] valid_load [1] dirty_load [0] dirty_in
  localparam logic [9:0] O_NONE     = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] O_RD_HIT   = 10'b1_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] O_WR_DIRTY = 10'b1_0_0_0_1_1_0_0_1_1;
  localparam logic [9:0] O_WR_BE0   = 10'b1_0_0_0_1_1_0_0_0_0;
  localparam logic [9:0] O_WB       = 10'b0_0_1_1_0_0_0_0_0_0;
  localparam logic [9:0] O_AL_WAIT  = 10'b0_1_0_0_0_0_0_0_0_0;
  localparam logic [9:0] O_AL_DONE  = 10'b0_1_0_0_0_1_1_1_1_0;

  typedef struct {
    string      name;
    logic [9:0] outs;
    logic [3:0] miss;
    logic [3:0] wb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec;
  int   n_err;
  logic [9:0] obs;

  assign obs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel,
                bus.data_src_sel, bus.data_load, bus.tag_load, bus.valid_load,
                bus.dirty_load, bus.dirty_in};

  // Monitor: compare whatever the DUT presents against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_vec++;
      if (obs !== cur.outs) begin
        n_err++;
        $display("FAIL %s outputs: got %b expected %b", cur.name, obs, cur.outs);
      end
      if (miss_count !== cur.miss) begin
        n_err++;
        $display("FAIL %s miss_count: got %0d expected %0d", cur.name, miss_count, cur.miss);
      end
      if (wb_count !== cur.wb) begin
        n_err++;
        $display("FAIL %s wb_count: got %0d expected %0d", cur.name, wb_count, cur.wb);
      end
    end
  end

  // Queue the expectation for the inputs currently driven, then advance one cycle.
  task automatic cyc(input string nm, input logic [9:0] e, input int m, input int w);
    exp_t x;
    x.name = nm;
    x.outs = e;
    x.miss = m[3:0];
    x.wb   = w[3:0];
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [1:0] be,
                        input logic h, input logic d, input logic pr);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.hit             = h;
    bus.dirty           = d;
    bus.pmem_resp       = pr;
  endtask

  // Reset pulse with an all-zero check while it is held.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    cyc(nm, O_NONE, 0, 0);
    rst_n = 1'b1;
  endtask

  // Safety net in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset holds every output low even with a read hit presented.
    cyc("reset_rd_hit", O_NONE, 0, 0);
    rst_n = 1'b1;

    // Read hit and write hits.
    set_in(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cyc("read_hit", O_RD_HIT, 0, 0);
    set_in(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0); cyc("write_hit_be10", O_WR_DIRTY, 0, 0);
    set_in(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0); cyc("write_hit_be00", O_WR_BE0, 0, 0);
    set_in(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0); cyc("rd_wr_is_write", O_WR_DIRTY, 0, 0);
    // Stray pmem_resp in IDLE changes nothing.
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); cyc("idle_pmem_resp", O_NONE, 0, 0);
    set_in(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cyc("still_idle", O_RD_HIT, 0, 0);

    // Clean read miss, memory answers on the fifth ALLOCATE cycle.
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("clean_miss", O_NONE, 0, 0);
    for (int i = 0; i < 4; i++) cyc("alloc_wait", O_AL_WAIT, 1, 0);
    bus.pmem_resp = 1'b1; cyc("alloc_done", O_AL_DONE, 1, 0);
    set_in(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cyc("miss_hit_resp", O_RD_HIT, 1, 0);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("miss_after", O_NONE, 1, 0);

    // Dirty write miss: writeback, allocate, then the merged write.
    do_reset("reset_a");
    set_in(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0); cyc("dirty_miss", O_NONE, 0, 0);
    cyc("wb_wait1", O_WB, 1, 0);
    cyc("wb_wait2", O_WB, 1, 0);
    bus.pmem_resp = 1'b1; cyc("wb_done", O_WB, 1, 0);
    bus.pmem_resp = 1'b0; cyc("wb_alloc_wait", O_AL_WAIT, 1, 1);
    bus.pmem_resp = 1'b1; cyc("wb_alloc_done", O_AL_DONE, 1, 1);
    set_in(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0); cyc("wb_merged_write", O_WR_DIRTY, 1, 1);
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("wb_after", O_NONE, 1, 1);

    // Reset in the middle of ALLOCATE: request and fill strobes drop at once.
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("rst_miss", O_NONE, 1, 1);
    cyc("rst_alloc", O_AL_WAIT, 2, 1);
    rst_n = 1'b0; bus.pmem_resp = 1'b1; cyc("rst_mid_alloc", O_NONE, 0, 0);
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("rst_release", O_NONE, 0, 0);
    set_in(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); cyc("rst_then_hit", O_RD_HIT, 0, 0);

    // CPU drops its request mid-miss: fill still completes, no mem_resp.
    set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("drop_miss", O_NONE, 0, 0);
    bus.mem_read = 1'b0; cyc("drop_alloc", O_AL_WAIT, 1, 0);
    bus.pmem_resp = 1'b1; cyc("drop_done", O_AL_DONE, 1, 0);
    bus.pmem_resp = 1'b0; cyc("drop_no_resp", O_NONE, 1, 0);

    // Sixteen misses saturate the 4-bit miss counter at 15.
    do_reset("reset_b");
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      cyc("sat_miss", O_NONE, i, 0);
      bus.pmem_resp = 1'b1;
      cyc("sat_fill", O_AL_DONE, (i + 1 > 15) ? 15 : i + 1, 0);
    end
    set_in(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); cyc("sat_hold", O_NONE, 15, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
